// File: rtl/const_bank.sv
// Run-time programmable constant bank with serial scan load and fixed one/zero ties.
// CONST_BANK_PARITY_EN appends an even-parity bit to every frame; USE_POWER_PINS/LVS add supply pins and decap.
module constant_block (
`ifdef USE_POWER_PINS
  inout  wire  vdd,
  inout  wire  vss,
`endif
  output logic one,
  output logic zero
);
  assign one  = 1'b1;
  assign zero = 1'b0;
endmodule

`ifdef LVS
module const_bank_decap (
`ifdef USE_POWER_PINS
  inout wire vdd,
  inout wire vss
`endif
);
endmodule
`endif

module const_bank #(
  parameter int             NCH       = 8,
  parameter logic [NCH-1:0] RESET_VAL = {NCH{1'b0}}
) (
`ifdef USE_POWER_PINS
  inout  wire            vdd,
  inout  wire            vss,
`endif
  input  logic           clk,
  input  logic           reset,
  input  logic           ser_in,
  input  logic           ser_shift,
  input  logic           ser_load,
  output logic           ser_out,
  output logic [NCH-1:0] const_out,
  output logic           load_ok,
  output logic           load_err,
  output logic           one,
  output logic           zero
);

`ifdef CONST_BANK_PARITY_EN
  localparam int FL = NCH + 1;
`else
  localparam int FL = NCH;
`endif
  localparam int CW = $clog2(FL + 2);

  logic [FL-1:0]  r_shreg;
  logic [CW-1:0]  r_cnt;
  logic [NCH-1:0] r_const;
  logic           r_ok;
  logic           r_err;

  logic           w_full;
  logic           w_accept;
  logic [NCH-1:0] w_data;

  assign w_full = (r_cnt == CW'(FL));

`ifdef CONST_BANK_PARITY_EN
  assign w_accept = w_full && !(^r_shreg);
  assign w_data   = r_shreg[NCH:1];
`else
  assign w_accept = w_full;
  assign w_data   = r_shreg[NCH-1:0];
`endif

  // cnt saturates one past FL so an overrun stays distinguishable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_const <= RESET_VAL;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ok  <= 1'b0;
      r_err <= 1'b0;
      if (ser_shift) begin
        r_shreg <= {r_shreg[FL-2:0], ser_in};
        if (r_cnt != CW'(FL + 1))
          r_cnt <= r_cnt + 1'b1;
        if (ser_load)
          r_err <= 1'b1;
      end else if (ser_load) begin
        r_cnt <= '0;
        if (w_accept) begin
          r_const <= w_data;
          r_ok    <= 1'b1;
        end else begin
          r_err   <= 1'b1;
        end
      end
    end
  end

  assign ser_out   = r_shreg[FL-1];
  assign const_out = r_const;
  assign load_ok   = r_ok;
  assign load_err  = r_err;

  constant_block u_tie (
`ifdef USE_POWER_PINS
    .vdd  (vdd),
    .vss  (vss),
`endif
    .one  (one),
    .zero (zero)
  );

`ifdef LVS
  const_bank_decap u_decap (
`ifdef USE_POWER_PINS
    .vdd (vdd),
    .vss (vss)
`endif
  );
`endif

endmodule

// File: tb/tb_const_bank.sv
// Directed testbench for const_bank (NCH=8, RESET_VAL=8'hA5).
// Frames carry an even-parity bit when CONST_BANK_PARITY_EN is defined.
module tb_const_bank;

`ifdef CONST_BANK_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ser_in = 1'b0;
  logic       ser_shift = 1'b0;
  logic       ser_load = 1'b0;
  logic       ser_out;
  logic [7:0] const_out;
  logic       load_ok;
  logic       load_err;
  logic       one;
  logic       zero;

  int errors = 0;
  int checks = 0;

  const_bank #(.NCH(8), .RESET_VAL(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .ser_in    (ser_in),
    .ser_shift (ser_shift),
    .ser_load  (ser_load),
    .ser_out   (ser_out),
    .const_out (const_out),
    .load_ok   (load_ok),
    .load_err  (load_err),
    .one       (one),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift bits[n-1] first down to bits[0].
  task automatic shift_seq(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ser_in    = bits[i];
      ser_shift = 1'b1;
      tick();
    end
    ser_shift = 1'b0;
  endtask

  function automatic logic [15:0] frame(input logic [7:0] v);
`ifdef CONST_BANK_PARITY_EN
    return {7'd0, v, ^v};
`else
    return {8'd0, v};
`endif
  endfunction

  task automatic load_pulse();
    ser_load = 1'b1;
    tick();
    ser_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (const_out !== 8'hA5) begin
      errors++;
      $display("FAIL reset_const got=%h exp=a5", const_out);
    end
    checks++;
    if (ser_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ser_out got=%b exp=0", ser_out);
    end
    checks++;
    if (load_ok !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses got=%b%b exp=00", load_ok, load_err);
    end
    checks++;
    if (one !== 1'b1 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_ties got=%b%b exp=10", one, zero);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (const_out !== 8'hA5) begin
      errors++;
      $display("FAIL post_reset_const got=%h exp=a5", const_out);
    end
  endtask

  task automatic test_short_frame();
    shift_seq(frame(8'h3C) >> 1, FL - 1);
    load_pulse();
    checks++;
    if (load_err !== 1'b1 || load_ok !== 1'b0) begin
      errors++;
      $display("FAIL short_pulses got=ok%b err%b exp=ok0 err1", load_ok, load_err);
    end
    checks++;
    if (const_out !== 8'hA5) begin
      errors++;
      $display("FAIL short_const got=%h exp=a5", const_out);
    end
    tick();
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL short_err_width got=%b exp=0", load_err);
    end
  endtask

  task automatic test_good_frame();
    shift_seq(frame(8'h3C), FL);
    checks++;
    if (ser_out !== 1'b0) begin
      errors++;
      $display("FAIL good_ser_out got=%b exp=0", ser_out);
    end
    checks++;
    if (const_out !== 8'hA5) begin
      errors++;
      $display("FAIL good_const_early got=%h exp=a5", const_out);
    end
    load_pulse();
    checks++;
    if (load_ok !== 1'b1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL good_pulses got=ok%b err%b exp=ok1 err0", load_ok, load_err);
    end
    checks++;
    if (const_out !== 8'h3C) begin
      errors++;
      $display("FAIL good_const got=%h exp=3c", const_out);
    end
    tick();
    checks++;
    if (load_ok !== 1'b0) begin
      errors++;
      $display("FAIL good_ok_width got=%b exp=0", load_ok);
    end
  endtask

  task automatic test_overrun();
    shift_seq(16'h1FFF, FL + 1);
    load_pulse();
    checks++;
    if (load_err !== 1'b1 || load_ok !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pulses got=ok%b err%b exp=ok0 err1", load_ok, load_err);
    end
    checks++;
    if (const_out !== 8'h3C) begin
      errors++;
      $display("FAIL overrun_const got=%h exp=3c", const_out);
    end
  endtask

  task automatic test_collision();
    logic [15:0] f;
    f = frame(8'hC3);
    shift_seq(f >> 1, FL - 1);
    ser_in    = f[0];
    ser_shift = 1'b1;
    ser_load  = 1'b1;
    tick();
    ser_shift = 1'b0;
    ser_load  = 1'b0;
    checks++;
    if (load_err !== 1'b1 || load_ok !== 1'b0) begin
      errors++;
      $display("FAIL collide_pulses got=ok%b err%b exp=ok0 err1", load_ok, load_err);
    end
    checks++;
    if (ser_out !== 1'b1) begin
      errors++;
      $display("FAIL collide_ser_out got=%b exp=1", ser_out);
    end
    checks++;
    if (const_out !== 8'h3C) begin
      errors++;
      $display("FAIL collide_const_hold got=%h exp=3c", const_out);
    end
    load_pulse();
    checks++;
    if (load_ok !== 1'b1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL collide_commit got=ok%b err%b exp=ok1 err0", load_ok, load_err);
    end
    checks++;
    if (const_out !== 8'hC3) begin
      errors++;
      $display("FAIL collide_const got=%h exp=c3", const_out);
    end
  endtask

  task automatic test_back_to_back();
    shift_seq(frame(8'h81), FL);
    load_pulse();
    checks++;
    if (load_ok !== 1'b1 || const_out !== 8'h81) begin
      errors++;
      $display("FAIL b2b_first got=ok%b %h exp=ok1 81", load_ok, const_out);
    end
    load_pulse();
    checks++;
    if (load_err !== 1'b1 || load_ok !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got=ok%b err%b exp=ok0 err1", load_ok, load_err);
    end
    checks++;
    if (const_out !== 8'h81) begin
      errors++;
      $display("FAIL b2b_const got=%h exp=81", const_out);
    end
  endtask

  task automatic test_mid_reset();
    shift_seq(frame(8'h3C), FL);
    load_pulse();
    checks++;
    if (const_out !== 8'h3C) begin
      errors++;
      $display("FAIL mid_setup got=%h exp=3c", const_out);
    end
    shift_seq(16'h000F, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (const_out !== 8'hA5) begin
      errors++;
      $display("FAIL mid_const got=%h exp=a5", const_out);
    end
    checks++;
    if (ser_out !== 1'b0 || load_ok !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_state got=%b%b%b exp=000", ser_out, load_ok, load_err);
    end
    load_pulse();
    checks++;
    if (load_err !== 1'b1 || const_out !== 8'hA5) begin
      errors++;
      $display("FAIL mid_load got=err%b %h exp=err1 a5", load_err, const_out);
    end
  endtask

`ifdef CONST_BANK_PARITY_EN
  task automatic test_parity();
    shift_seq({7'd0, 8'h3C, 1'b0}, 9);
    load_pulse();
    checks++;
    if (load_ok !== 1'b1 || const_out !== 8'h3C) begin
      errors++;
      $display("FAIL par_good got=ok%b %h exp=ok1 3c", load_ok, const_out);
    end
    shift_seq({7'd0, 8'h3D, 1'b0}, 9);
    load_pulse();
    checks++;
    if (load_err !== 1'b1 || load_ok !== 1'b0) begin
      errors++;
      $display("FAIL par_bad got=ok%b err%b exp=ok0 err1", load_ok, load_err);
    end
    checks++;
    if (const_out !== 8'h3C) begin
      errors++;
      $display("FAIL par_bad_const got=%h exp=3c", const_out);
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_short_frame();
    test_good_frame();
    test_overrun();
    test_collision();
    test_back_to_back();
    test_mid_reset();
`ifdef CONST_BANK_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
